register_bank: RTL and testbench

REGISTER_BANK -- requirements
Module: register_bank

---
 rtl/register_bank_if.sv | 20 ++
 rtl/register_bank.sv | 79 +++++++
 tb/tb_register_bank.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/register_bank_if.sv
// register_bank_if: operation, load and read-port bundle for register_bank.
interface register_bank_if #(
  parameter int WIDTH = 16,
  parameter int COUNT = 4
) ();
  // One spare select bit when COUNT is a power of two so out-of-range codes can be driven.
  localparam int SEL_W = $clog2(COUNT + 1);
  logic [2:0] FunSel;
  logic [WIDTH-1:0] I;
  logic [COUNT-1:0] RegSel;
  logic [SEL_W-1:0] OutASel;
  logic [SEL_W-1:0] OutBSel;
  logic [WIDTH-1:0] OutA;
  logic [WIDTH-1:0] OutB;
  logic Z;
  logic N;
  logic C;
  modport master (output FunSel, I, RegSel, OutASel, OutBSel, input OutA, OutB, Z, N, C);
  modport slave (input FunSel, I, RegSel, OutASel, OutBSel, output OutA, OutB, Z, N, C);
endinterface

// File: rtl/register_bank.sv
// register_bank: multi-write register file with inc/dec/load/half-load ops, two read ports and status flags.
module register_bank #(
  parameter int WIDTH = 16,
  parameter int COUNT = 4,
  parameter bit SATURATE = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input logic Clock,
  input logic Reset,
  register_bank_if.slave bus
);
  localparam int H = WIDTH / 2;
  localparam int SEL_W = $clog2(COUNT + 1);
  if (WIDTH % 2 != 0 || WIDTH < 4 || COUNT < 2 || COUNT > 16) begin : g_bad_params
    $error("register_bank: WIDTH must be even and >= 4, COUNT must be 2..16");
  end
  logic [WIDTH-1:0] regs_q [COUNT];
  logic [WIDTH-1:0] regs_d [COUNT];
  logic [WIDTH:0] res [COUNT];
  logic z_q, n_q, c_q, z_d, n_d, c_d;
  logic [WIDTH-1:0] out_a, out_b;
  // Returns {carry, new value}; carry flags an inc/dec that hit an unsigned limit.
  function automatic logic [WIDTH:0] apply_op(input logic [WIDTH-1:0] q, input logic [2:0] f,
                                             input logic [WIDTH-1:0] d);
    logic [H-1:0] lo;
    lo = d[H-1:0];
    case (f)
      3'd0: return (q == '0) ? {1'b1, SATURATE ? q : {WIDTH{1'b1}}} : {1'b0, q - 1'b1};
      3'd1: return (&q) ? {1'b1, SATURATE ? q : {WIDTH{1'b0}}} : {1'b0, q + 1'b1};
      3'd2: return {1'b0, d};
      3'd3: return '0;
      3'd4: return {1'b0, {H{1'b0}}, lo};
      3'd5: return {1'b0, q[WIDTH-1:H], lo};
      3'd6: return {1'b0, lo, q[H-1:0]};
      default: return {1'b0, {H{lo[H-1]}}, lo};
    endcase
  endfunction
  // Walking downward leaves the flags from the lowest-index enabled register.
  always_comb begin
    z_d = z_q;
    n_d = n_q;
    c_d = c_q;
    for (int k = COUNT - 1; k >= 0; k--) begin
      res[k] = apply_op(regs_q[k], bus.FunSel, bus.I);
      regs_d[k] = bus.RegSel[k] ? res[k][WIDTH-1:0] : regs_q[k];
      if (bus.RegSel[k]) begin
        z_d = res[k][WIDTH-1:0] == '0;
        n_d = res[k][WIDTH-1];
        c_d = res[k][WIDTH];
      end
    end
  end
  always_comb begin
    out_a = '0;
    out_b = '0;
    for (int k = 0; k < COUNT; k++) begin
      out_a = (bus.OutASel == SEL_W'(k)) ? regs_q[k] : out_a;
      out_b = (bus.OutBSel == SEL_W'(k)) ? regs_q[k] : out_b;
    end
  end
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      regs_q <= '{default: RESET_VALUE};
      z_q <= 1'b0;
      n_q <= 1'b0;
      c_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      z_q <= z_d;
      n_q <= n_d;
      c_q <= c_d;
    end
  end
  assign bus.OutA = out_a;
  assign bus.OutB = out_b;
  assign bus.Z = z_q;
  assign bus.N = n_q;
  assign bus.C = c_q;
endmodule

// File: tb/tb_register_bank.sv
// tb_register_bank: wrapping and saturating banks driven in lockstep, checked against an arithmetic model.
module tb_register_bank;
  localparam int W = 16;
  localparam int CNT = 4;
  localparam int SW = $clog2(CNT + 1);
  localparam int unsigned LIMIT = 32'hFFFF;
  localparam int unsigned HB = 256;
  localparam int unsigned RV [2] = '{32'h0000, 32'h00A5};
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  register_bank_if #(.WIDTH(W), .COUNT(CNT)) bw ();
  register_bank_if #(.WIDTH(W), .COUNT(CNT)) bs ();
  register_bank #(.WIDTH(W), .COUNT(CNT), .SATURATE(1'b0), .RESET_VALUE(16'h0000))
    dut_wrap (.Clock(clk), .Reset(rst_n), .bus(bw.slave));
  register_bank #(.WIDTH(W), .COUNT(CNT), .SATURATE(1'b1), .RESET_VALUE(16'h00A5))
    dut_sat (.Clock(clk), .Reset(rst_n), .bus(bs.slave));
  int unsigned m [2][CNT];
  int unsigned mz [2], mn [2], mc [2];
  int vectors = 0;
  int miscompares = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < CNT; k++) m[d][k] = RV[d];
      mz[d] = 0; mn[d] = 0; mc[d] = 0;
    end
  endtask
  // d = 0 wraps, d = 1 clamps at the unsigned limits.
  task automatic model_op(input int f, input int unsigned i, input int sel);
    int unsigned q, nv, lo, c;
    bit first;
    lo = i % HB;
    for (int d = 0; d < 2; d++) begin
      first = 1;
      for (int k = 0; k < CNT; k++) begin
        if (((sel >> k) & 1) == 1) begin
          q = m[d][k];
          c = 0;
          case (f)
            0: if (q == 0) begin c = 1; nv = (d == 1) ? 0 : LIMIT; end else nv = q - 1;
            1: if (q == LIMIT) begin c = 1; nv = (d == 1) ? LIMIT : 0; end else nv = q + 1;
            2: nv = i;
            3: nv = 0;
            4: nv = lo;
            5: nv = (q / HB) * HB + lo;
            6: nv = lo * HB + q % HB;
            default: nv = (lo >= HB / 2) ? lo + (LIMIT + 1 - HB) : lo;
          endcase
          m[d][k] = nv;
          if (first) begin
            mz[d] = (nv == 0) ? 1 : 0;
            mn[d] = (nv >= (LIMIT + 1) / 2) ? 1 : 0;
            mc[d] = c;
            first = 0;
          end
        end
      end
    end
  endtask
  task automatic drive(input int f, input int unsigned i, input int sel);
    bw.FunSel = 3'(f); bs.FunSel = 3'(f);
    bw.I = W'(i); bs.I = W'(i);
    bw.RegSel = CNT'(sel); bs.RegSel = CNT'(sel);
  endtask
  task automatic check_all(input string tag);
    for (int k = 0; k < CNT; k++) begin
      bw.OutASel = SW'(k); bs.OutASel = SW'(k);
      bw.OutBSel = SW'(CNT - 1 - k); bs.OutBSel = SW'(CNT - 1 - k);
      #1;
      check($sformatf("%s/wrapA%0d", tag, k), 32'(bw.OutA), m[0][k]);
      check($sformatf("%s/wrapB%0d", tag, CNT - 1 - k), 32'(bw.OutB), m[0][CNT - 1 - k]);
      check($sformatf("%s/satA%0d", tag, k), 32'(bs.OutA), m[1][k]);
      check($sformatf("%s/satB%0d", tag, CNT - 1 - k), 32'(bs.OutB), m[1][CNT - 1 - k]);
    end
    check({tag, "/wrapZ"}, 32'(bw.Z), mz[0]);
    check({tag, "/wrapN"}, 32'(bw.N), mn[0]);
    check({tag, "/wrapC"}, 32'(bw.C), mc[0]);
    check({tag, "/satZ"}, 32'(bs.Z), mz[1]);
    check({tag, "/satN"}, 32'(bs.N), mn[1]);
    check({tag, "/satC"}, 32'(bs.C), mc[1]);
  endtask
  // Port A still points at the last register swept, so it must show the pre-edge value.
  task automatic step(input string tag, input int f, input int unsigned i, input int sel);
    drive(f, i, sel);
    #1;
    check({tag, "/preedge"}, 32'(bw.OutA), m[0][CNT - 1]);
    check({tag, "/preedgeSat"}, 32'(bs.OutA), m[1][CNT - 1]);
    model_op(f, i, sel);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask
  initial begin
    int f, sel;
    int unsigned i;
    rst_n = 1'b0;
    drive(2, 32'h1234, 15);
    bw.OutASel = '0; bw.OutBSel = '0; bs.OutASel = '0; bs.OutBSel = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;
    step("load", 2, 32'hABCD, 1);
    step("r1set", 2, 32'hFFFF, 2);
    step("r1inc", 1, 0, 2);
    step("r1dec", 0, 0, 2);
    step("r2clr", 3, 0, 4);
    step("r2dec", 0, 0, 4);
    step("r2max", 2, 32'hFFFF, 4);
    step("r2inc", 1, 0, 4);
    step("r0set", 2, 32'h1234, 1);
    step("sext", 7, 32'h0080, 1);
    step("zext", 4, 32'h0080, 1);
    step("r0set2", 2, 32'h1234, 1);
    step("lohalf", 5, 32'h0080, 1);
    step("r0set3", 2, 32'h1234, 1);
    step("hihalf", 6, 32'h0080, 1);
    step("r0five", 2, 5, 1);
    step("r3nine", 2, 9, 8);
    step("multi", 1, 0, 9);
    step("hold", 1, 0, 0);
    for (int s = CNT; s < (1 << SW); s++) begin
      bw.OutASel = SW'(s); bw.OutBSel = SW'(s); bs.OutASel = SW'(s); bs.OutBSel = SW'(s);
      #1;
      check($sformatf("oor/wrapA%0d", s), 32'(bw.OutA), 0);
      check($sformatf("oor/wrapB%0d", s), 32'(bw.OutB), 0);
      check($sformatf("oor/satA%0d", s), 32'(bs.OutA), 0);
    end
    drive(1, 0, 15);
    @(posedge clk);
    #2;
    model_op(1, 0, 15);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("asyncrst");
    @(posedge clk);
    #1;
    check_all("rsthold");
    rst_n = 1'b1;
    step("postrst", 1, 0, 15);
    for (int n = 0; n < 400; n++) begin
      f = int'($urandom_range(0, 7));
      sel = int'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: i = 0;
        1: i = LIMIT;
        2: i = $urandom_range(0, 3) * 32'h4000 + 32'h7F + $urandom_range(0, 1);
        default: i = $urandom & LIMIT;
      endcase
      step($sformatf("rnd%0d", n), f, i, sel);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
